bin_stream_mux: RTL and testbench

BIN_STREAM_MUX -- requirements
Module: bin_stream_mux

---
 rtl/bin_stream_mux.sv | 92 +++++++++
 tb/tb_bin_stream_mux.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/bin_stream_mux.sv
// bin_stream_mux: packet-aware N:1 stream mux with explicit-select or round-robin arbitration
module bin_stream_mux #(
    parameter int NUM_IN = 16,
    parameter int WIDTH  = 8,
    localparam int SEL_W = $clog2(NUM_IN)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    mode_i,
    input  logic [SEL_W-1:0]        sel_i,
    input  logic [NUM_IN*WIDTH-1:0] in_data_i,
    input  logic [NUM_IN-1:0]       in_valid_i,
    input  logic [NUM_IN-1:0]       in_last_i,
    output logic [NUM_IN-1:0]       in_ready_o,
    output logic [WIDTH-1:0]        out_data_o,
    output logic                    out_valid_o,
    output logic                    out_last_o,
    output logic [SEL_W-1:0]        out_chan_o,
    input  logic                    out_ready_i,
    output logic                    busy_o
);
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t           state_q, state_d;
    logic [SEL_W-1:0] lock_q, lock_d, rr_ptr_q, rr_ptr_d, cand;
    logic             cand_ok, load_ok, accept;
    assign busy_o = state_q == LOCKED;
    // candidate: locked channel, else explicit select, else first valid searching up from rr_ptr
    always_comb begin
        int idx;
        idx     = 0;
        cand    = '0;
        cand_ok = 1'b0;
        if (state_q == LOCKED) begin
            cand    = lock_q;
            cand_ok = 1'b1;
        end else if (!mode_i) begin
            cand    = sel_i;
            cand_ok = 32'(sel_i) < NUM_IN;
        end else begin
            for (int i = NUM_IN - 1; i >= 0; i--) begin
                idx = int'(rr_ptr_q) + i;
                if (idx >= NUM_IN) idx = idx - NUM_IN;
                if (in_valid_i[idx]) begin
                    cand    = SEL_W'(idx);
                    cand_ok = 1'b1;
                end
            end
        end
    end
    // handshake and next-state: ready only toward the candidate, lock on non-last beats
    always_comb begin
        load_ok    = !out_valid_o || out_ready_i;
        in_ready_o = (rst_ni && cand_ok && load_ok) ? (NUM_IN'(1) << cand) : '0;
        accept     = in_valid_i[cand] && in_ready_o[cand];
        state_d    = state_q;
        lock_d     = lock_q;
        rr_ptr_d   = rr_ptr_q;
        if (accept) begin
            state_d = in_last_i[cand] ? IDLE : LOCKED;
            lock_d  = cand;
            if (in_last_i[cand]) rr_ptr_d = (32'(cand) == NUM_IN - 1) ? '0 : cand + 1'b1;
        end
    end
    // state, lock and round-robin pointer registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            lock_q   <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            lock_q   <= lock_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end
    // output register: load on acceptance, drop valid when drained with nothing new
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_last_o  <= 1'b0;
            out_chan_o  <= '0;
        end else if (accept) begin
            out_valid_o <= 1'b1;
            out_data_o  <= in_data_i[int'(cand)*WIDTH +: WIDTH];
            out_last_o  <= in_last_i[cand];
            out_chan_o  <= cand;
        end else if (load_ok) begin
            out_valid_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_bin_stream_mux.sv
// tb_bin_stream_mux: scoreboard bench with a behavioural arbitration model
module tb_bin_stream_mux;
    localparam int N = 16;
    localparam int W = 8;
    localparam int S = 4;
    typedef struct {
        int           ch;
        logic [W-1:0] d;
        logic         l;
    } beat_t;
    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           mode = 1'b0;
    logic [S-1:0]   sel = '0;
    logic [N*W-1:0] in_data = '0;
    logic [N-1:0]   in_valid = '0;
    logic [N-1:0]   in_last = '0;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic           out_valid, out_last, busy;
    logic           out_ready = 1'b1;
    logic [S-1:0]   out_chan;
    logic           s_mode = 1'b0;
    logic [3:0]     s_sel = 4'd13;
    logic [12*W-1:0] s_data = '1;
    logic [11:0]    s_valid = '1;
    logic [11:0]    s_last = '1;
    logic [11:0]    s_ready;
    logic [W-1:0]   s_out_data;
    logic           s_out_valid, s_out_last, s_busy;
    logic [3:0]     s_out_chan;
    beat_t          sb[$];
    int             owner = -1;
    int             ptr = 0;
    bit             m_valid = 1'b0;
    int             checks = 0;
    int             errors = 0;
    always #5 clk = ~clk;
    bin_stream_mux #(.NUM_IN(N), .WIDTH(W)) dut (
        .clk_i(clk), .rst_ni(rst_n), .mode_i(mode), .sel_i(sel),
        .in_data_i(in_data), .in_valid_i(in_valid), .in_last_i(in_last), .in_ready_o(in_ready),
        .out_data_o(out_data), .out_valid_o(out_valid), .out_last_o(out_last), .out_chan_o(out_chan),
        .out_ready_i(out_ready), .busy_o(busy)
    );
    bin_stream_mux #(.NUM_IN(12), .WIDTH(W)) dut12 (
        .clk_i(clk), .rst_ni(rst_n), .mode_i(s_mode), .sel_i(s_sel),
        .in_data_i(s_data), .in_valid_i(s_valid), .in_last_i(s_last), .in_ready_o(s_ready),
        .out_data_o(s_out_data), .out_valid_o(s_out_valid), .out_last_o(s_out_last), .out_chan_o(s_out_chan),
        .out_ready_i(1'b1), .busy_o(s_busy)
    );
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic set_ch(input int c, input logic [W-1:0] d, input logic l, input logic v);
        in_data[c*W +: W] = d;
        in_last[c]        = l;
        in_valid[c]       = v;
    endtask
    function automatic int m_cand();
        if (owner >= 0) return owner;
        if (!mode) return (int'(sel) < N) ? int'(sel) : -1;
        for (int k = 0; k < N; k++)
            if (in_valid[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction
    // called at posedge+1 with inputs set; returns at the next posedge+1
    task automatic cycle();
        int           c;
        bit           lok, acc;
        logic [N-1:0] exp_rdy;
        #1;
        lok     = !m_valid || out_ready;
        c       = m_cand();
        exp_rdy = '0;
        if (c >= 0 && lok) exp_rdy[c] = 1'b1;
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        chk("busy", 64'(busy), 64'(owner >= 0));
        acc = c >= 0 && lok && in_valid[c];
        if (acc) begin
            sb.push_back('{c, in_data[c*W +: W], in_last[c]});
            if (in_last[c]) begin
                owner = -1;
                ptr   = (c + 1) % N;
            end else begin
                owner = c;
            end
        end
        m_valid = acc || (!lok && m_valid);
        @(posedge clk);
        #1;
    endtask
    always @(negedge clk) begin
        beat_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got chan %0d data %0h expected no beat at %0t", out_chan, out_data, $time);
            end else begin
                e = sb.pop_front();
                chk("sb_data", 64'(out_data), 64'(e.d));
                chk("sb_chan", 64'(out_chan), 64'(e.ch));
                chk("sb_last", 64'(out_last), 64'(e.l));
            end
        end
    end
    initial begin
        int rr_exp[4] = '{2, 7, 15, 2};
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(out_valid), 0);
        chk("rst_ready", 64'(in_ready), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_ready12", 64'(s_ready), 0);
        rst_n = 1'b1;
        mode = 1'b0; sel = 4'd5; set_ch(5, 8'hA1, 1'b1, 1'b1);
        cycle();
        in_valid = '0;
        chk("t1_data", 64'(out_data), 64'hA1);
        chk("t1_chan", 64'(out_chan), 5);
        chk("t1_last", 64'(out_last), 1);
        chk("t1_busy", 64'(busy), 0);
        sel = 4'd1; set_ch(1, 8'h01, 1'b1, 1'b1);
        cycle();
        in_valid = '0;
        mode = 1'b1;
        set_ch(2, 8'h22, 1'b1, 1'b1); set_ch(7, 8'h77, 1'b1, 1'b1); set_ch(15, 8'hFF, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("rr_chan", 64'(out_chan), 64'(rr_exp[i]));
        end
        in_valid = '0; in_last = '0;
        mode = 1'b0; sel = 4'd3;
        set_ch(3, 8'h31, 1'b0, 1'b1); set_ch(9, 8'h91, 1'b1, 1'b1);
        cycle();
        chk("t3_b1_busy", 64'(busy), 1);
        sel = 4'd9; set_ch(3, 8'h32, 1'b0, 1'b1);
        cycle();
        chk("t3_b2_chan", 64'(out_chan), 3);
        chk("t3_b2_busy", 64'(busy), 1);
        set_ch(3, 8'h33, 1'b1, 1'b1);
        cycle();
        chk("t3_b3_chan", 64'(out_chan), 3);
        chk("t3_b3_busy", 64'(busy), 0);
        in_valid[3] = 1'b0;
        cycle();
        chk("t3_ch9", 64'(out_chan), 9);
        in_valid = '0; sel = 4'd0;
        set_ch(0, 8'h5C, 1'b1, 1'b1);
        cycle();
        out_ready = 1'b0; set_ch(0, 8'h11, 1'b1, 1'b1);
        repeat (4) begin
            cycle();
            chk("hold_data", 64'(out_data), 64'h5C);
            chk("hold_ready", 64'(in_ready), 0);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_ch(0, W'(8'h11 + i), 1'b1, 1'b1);
            cycle();
            chk("b2b_valid", 64'(out_valid), 1);
            chk("b2b_data", 64'(out_data), 64'(8'h11 + i));
        end
        in_valid = '0;
        repeat (2) begin
            cycle();
            chk("sel_oob_ready", 64'(s_ready), 0);
            chk("sel_oob_valid", 64'(s_out_valid), 0);
        end
        sel = 4'd4; set_ch(4, 8'h40, 1'b0, 1'b1);
        cycle();
        set_ch(4, 8'h41, 1'b0, 1'b1);
        cycle();
        chk("pre_rst_busy", 64'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 0);
        chk("arst_data", 64'(out_data), 0);
        chk("arst_last", 64'(out_last), 0);
        chk("arst_chan", 64'(out_chan), 0);
        chk("arst_busy", 64'(busy), 0);
        chk("arst_ready", 64'(in_ready), 0);
        owner = -1; ptr = 0; m_valid = 1'b0; sb.delete();
        in_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        sel = 4'd6; set_ch(6, 8'h66, 1'b1, 1'b1);
        cycle();
        chk("post_rst_valid", 64'(out_valid), 1);
        chk("post_rst_chan", 64'(out_chan), 6);
        chk("post_rst_data", 64'(out_data), 64'h66);
        chk("post_rst_busy", 64'(busy), 0);
        for (int t = 0; t < 3000; t++) begin
            if (t % 64 == 0) mode = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) sel = S'($urandom_range(0, N - 1));
            out_ready = $urandom_range(0, 9) < 7;
            for (int k = 0; k < N; k++)
                set_ch(k, W'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0);
            cycle();
        end
        in_valid = '0; out_ready = 1'b1;
        repeat (4) cycle();
        chk("sb_empty", 64'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
